armleocpu_regfile_wb_arbiter: RTL and testbench
===============================================

// Module: armleocpu_regfile_wb_arbiter
// PURPOSE
//  Shares the single regfile write port between two writeback requesters: req0 (load/CSR, older stage) and req1 (ALU, younger).
//  Each requester has a one-entry hold register. A round-robin arbiter drains one hold per cycle into rd_write/rd_addr/rd_wdata.
//  Reports pending writes for rs1/rs2 so decode can stall on hazards.
//  Optionally zeroes x1..x31 after reset.
// PARAMETERS
//  DATA_WIDTH  32  regfile data width
//  ADDR_WIDTH  5   regfile address width; highest register index is 2**ADDR_WIDTH-1
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  reqN_valid   in   1   requester N (N=0,1) presents a write
//  reqN_ready   out  1   hold register N can accept this cycle
//  reqN_addr    in   ADDR_WIDTH  destination register
//  reqN_wdata   in   DATA_WIDTH  write data
//  rs1_addr     in   ADDR_WIDTH  decode source 1
//  rs2_addr     in   ADDR_WIDTH  decode source 2
//  rs1_pending  out  1   a held, uncommitted write targets rs1_addr
//  rs2_pending  out  1   a held, uncommitted write targets rs2_addr
//  rd_write     out  1   regfile write enable
//  rd_addr      out  ADDR_WIDTH  regfile write address
//  rd_wdata     out  DATA_WIDTH  regfile write data
//  busy         out  1   clear sequence in progress
// BEHAVIOUR
//  - Reset (rst high): holds invalid, last_grant=1 (req0 wins first), age=0, state=CLEAR if macro else RUN.
//    All outputs are 0 while rst is high, including ready.
//  - Handshake: transfer when reqN_valid && reqN_ready at posedge.
//    reqN_ready = (state==RUN) && (!holdN_valid || holdN granted this cycle), which gives 1 write/cycle/requester throughput.
//  - Writes with addr==0 are accepted (ready honoured), then discarded: never held, never written.
//  - Latency: accepted at edge E. rd_write is driven from the hold during cycle E..E+1. The regfile commits at edge E+1.
//  - Outputs rd_* are combinational from the hold registers and the grant. When no hold is valid: rd_write=0, rd_addr=0, rd_wdata=0.
//  - Arbitration: exactly one hold is granted per cycle.
//    Only one hold valid: grant it.
//    Both valid: grant !last_grant. last_grant updates to the granted index.
//  - Ordering exception: both holds valid with equal addr means the older one is granted first, regardless of round-robin.
//    Age bit records acceptance order. Same-edge acceptance counts req0 as older.
//  - Granted hold clears at the edge unless refilled by a simultaneous accept.
//  - rsK_pending = OR over N of (holdN_valid && holdN_addr==rsK_addr), forced 0 when rsK_addr==0. Purely combinational.
//  - FSM (macro on): CLEAR -> RUN.
//    In CLEAR: busy=1, readies=0, rd_write=1, rd_addr=cnt, rd_wdata=0.
//    cnt starts at 1 and increments each cycle. Leave CLEAR after cnt==2**ADDR_WIDTH-1 is written (31 cycles for ADDR_WIDTH=5).
//    RUN is terminal until reset.
//  - Reset asserted mid-clear or mid-drain: holds dropped, sequence restarts from cnt=1.
// CONFIGURATION
//  ARMLEOCPU_REGFILE_CLEAR_EN
//   defined: CLEAR state exists as above.
//   undefined: no CLEAR state or counter; busy tied 0; RUN from reset. Register contents after reset are those of the regfile.
// TESTING
//  1. Macro on, release rst -> busy=1 for 31 cycles, rd_write with addr 1..31 and wdata 0, then busy=0 and both ready=1.
//  2. Single write: req0 addr=5 data=FF00FF00 -> next cycle rd_write=1, rd_addr=5, rd_wdata=FF00FF00, rs1_pending=1 when rs1_addr=5, then 0.
//  3. Both requesters valid every cycle (req0 addr 3, req1 addr 4) -> writes alternate 3,4,3,4 starting with 3.
//     Each ready toggles, giving 1 write/cycle total.
//  4. Same edge: req0 addr=7 data=1 and req1 addr=7 data=2 -> rd writes 7<-1 then 7<-2; pending for 7 stays high until the second commit.
//  5. req1 addr=0 valid -> ready=1, no rd_write, rs pending never set.
//  6. Assert rst mid-clear (cnt=10) and mid-drain (both holds valid) -> outputs 0 immediately. After release the clear restarts at 1 and old holds are never written.

Source files
------------

// File: rtl/armleocpu_regfile_wb_arbiter.sv
// Regfile writeback arbiter: two one-entry hold registers (req0 = load/CSR,
// req1 = ALU) drained round-robin into the single regfile write port, with
// rs1/rs2 pending-write reporting for decode hazard stalls.
// Optional post-reset clear of x1..x(2**ADDR_WIDTH-1): ARMLEOCPU_REGFILE_CLEAR_EN.
module armleocpu_regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_pending,
  output logic                  rs2_pending,
  output logic                  rd_write,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic                  busy
);

  logic                  run;
  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clear_addr;

`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;

  // State register and clear counter; counter starts at x1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= ADDR_WIDTH'(1);
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) cnt <= cnt + ADDR_WIDTH'(1);
    end
  end

  // Next state: leave CLEAR once the highest register has been written
  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && cnt == '1) state_nxt = S_RUN;
  end

  // State decode; everything is held quiet while rst is high
  always_comb begin
    run        = !rst && (state == S_RUN);
    clearing   = !rst && (state == S_CLEAR);
    clear_addr = cnt;
  end
`else
  // No clear sequence: running whenever reset is released
  always_comb begin
    run        = !rst;
    clearing   = 1'b0;
    clear_addr = '0;
  end
`endif

  logic                  h0_valid, h1_valid;
  logic [ADDR_WIDTH-1:0] h0_addr, h1_addr;
  logic [DATA_WIDTH-1:0] h0_data, h1_data;
  logic                  last_grant;
  logic                  age;        // 1: hold1 is older than hold0
  logic                  grant;      // index of the granted hold
  logic                  grant0, grant1;
  logic                  keep0, keep1;

  // Grant selection: single valid hold wins; two holds to the same register
  // drain oldest first, otherwise round-robin against last_grant
  always_comb begin
    grant = 1'b0;
    if (h0_valid && h1_valid)
      grant = (h0_addr == h1_addr) ? age : !last_grant;
    else if (h1_valid)
      grant = 1'b1;
    grant0     = run && h0_valid && !grant;
    grant1     = run && h1_valid && grant;
    req0_ready = run && (!h0_valid || grant0);
    req1_ready = run && (!h1_valid || grant1);
    keep0      = req0_valid && req0_ready && (req0_addr != '0);
    keep1      = req1_valid && req1_ready && (req1_addr != '0);
  end

  // Hold registers, round-robin pointer and acceptance-order bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h0_valid   <= 1'b0;
      h0_addr    <= '0;
      h0_data    <= '0;
      h1_valid   <= 1'b0;
      h1_addr    <= '0;
      h1_data    <= '0;
      last_grant <= 1'b1;
      age        <= 1'b0;
    end else begin
      if (keep0) begin
        h0_valid <= 1'b1;
        h0_addr  <= req0_addr;
        h0_data  <= req0_wdata;
      end else if (grant0) begin
        h0_valid <= 1'b0;
      end
      if (keep1) begin
        h1_valid <= 1'b1;
        h1_addr  <= req1_addr;
        h1_data  <= req1_wdata;
      end else if (grant1) begin
        h1_valid <= 1'b0;
      end
      if (grant0 || grant1) last_grant <= grant;
      // A lone new entry is younger than whatever the other hold keeps;
      // simultaneous entries treat req0 as older
      if (keep0 || keep1) age <= keep0 && !keep1;
    end
  end

  // Regfile write port and hazard reporting
  always_comb begin
    rd_write = 1'b0;
    rd_addr  = '0;
    rd_wdata = '0;
    if (clearing) begin
      rd_write = 1'b1;
      rd_addr  = clear_addr;
    end else if (grant0) begin
      rd_write = 1'b1;
      rd_addr  = h0_addr;
      rd_wdata = h0_data;
    end else if (grant1) begin
      rd_write = 1'b1;
      rd_addr  = h1_addr;
      rd_wdata = h1_data;
    end
    rs1_pending = (rs1_addr != '0) &&
                  ((h0_valid && h0_addr == rs1_addr) || (h1_valid && h1_addr == rs1_addr));
    rs2_pending = (rs2_addr != '0) &&
                  ((h0_valid && h0_addr == rs2_addr) || (h1_valid && h1_addr == rs2_addr));
    busy = clearing;
  end

endmodule

// File: tb/tb_armleocpu_regfile_wb_arbiter.sv
// Directed bench for armleocpu_regfile_wb_arbiter: vector table for the
// steady-state arbitration cases plus hand sequences for reset and clear.
module tb_armleocpu_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, rs1_addr, rs2_addr, rd_addr;
  logic [31:0] req0_wdata, req1_wdata, rd_wdata;
  logic        rs1_pending, rs2_pending, rd_write, busy;

  int n_checks = 0;
  int n_fail   = 0;

  armleocpu_regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0v; logic [4:0] r0a; logic [31:0] r0d;
    logic        r1v; logic [4:0] r1a; logic [31:0] r1d;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        w;   logic [4:0] a;   logic [31:0] d;
    logic        y0;  logic       y1;  logic p1; logic p2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_write"}, 64'(rd_write), 64'd0);
    chk({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, " rd_wdata"}, 64'(rd_wdata), 64'd0);
    chk({tag, " ready0"}, 64'(req0_ready), 64'd0);
    chk({tag, " ready1"}, 64'(req1_ready), 64'd0);
    chk({tag, " pend1"}, 64'(rs1_pending), 64'd0);
    chk({tag, " pend2"}, 64'(rs2_pending), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
  endtask

`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
  // Walk n clear cycles starting at x1; ends at the start of cycle n+1
  task automatic clear_seq(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("clr busy", 64'(busy), 64'd1);
      chk("clr rd_write", 64'(rd_write), 64'd1);
      chk("clr rd_addr", 64'(rd_addr), 64'(i));
      chk("clr rd_wdata", 64'(rd_wdata), 64'd0);
      chk("clr ready0", 64'(req0_ready), 64'd0);
      chk("clr ready1", 64'(req1_ready), 64'd0);
      next_cycle();
    end
  endtask
`endif

  task automatic post_reset_run();
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
    clear_seq(31);
`endif
    @(negedge clk);
    chk("run busy", 64'(busy), 64'd0);
    chk("run ready0", 64'(req0_ready), 64'd1);
    chk("run ready1", 64'(req1_ready), 64'd1);
    chk("run rd_write", 64'(rd_write), 64'd0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    rs1_addr = '0; rs2_addr = '0;

    // r0v r0a r0d  r1v r1a r1d  rs1 rs2  w a d  y0 y1 p1 p2
    // both requesters streaming: 3,4,3,4 starting with req0
    vecs.push_back(vec_t'{1,3,32'h33, 1,4,32'h44, 3,4, 0,0,32'h0,        1,1, 0,0});
    vecs.push_back(vec_t'{1,3,32'h35, 1,4,32'h45, 3,4, 1,3,32'h33,       1,0, 1,1});
    vecs.push_back(vec_t'{1,3,32'h36, 1,4,32'h46, 3,4, 1,4,32'h44,       0,1, 1,1});
    vecs.push_back(vec_t'{1,3,32'h37, 1,4,32'h47, 3,4, 1,3,32'h35,       1,0, 1,1});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  3,4, 1,4,32'h46,       0,1, 1,1});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  3,4, 1,3,32'h37,       1,1, 1,0});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  3,4, 0,0,32'h0,        1,1, 0,0});
    // single write from req0
    vecs.push_back(vec_t'{1,5,32'hFF00FF00, 0,0,32'h0, 5,0, 0,0,32'h0,   1,1, 0,0});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  5,0, 1,5,32'hFF00FF00, 1,1, 1,0});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  5,0, 0,0,32'h0,        1,1, 0,0});
    // same-edge writes to x7: older (req0) first even though round-robin favours req1
    vecs.push_back(vec_t'{1,7,32'h1,  1,7,32'h2,  7,7, 0,0,32'h0,        1,1, 0,0});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  7,7, 1,7,32'h1,        1,0, 1,1});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  7,7, 1,7,32'h2,        1,1, 1,1});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  7,7, 0,0,32'h0,        1,1, 0,0});
    // x0 write accepted and discarded
    vecs.push_back(vec_t'{0,0,32'h0,  1,0,32'hDEAD, 0,0, 0,0,32'h0,      1,1, 0,0});
    vecs.push_back(vec_t'{0,0,32'h0,  0,0,32'h0,  0,0, 0,0,32'h0,        1,1, 0,0});

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in reset");
    rst = 1'b0;
    post_reset_run();

    foreach (vecs[i]) begin
      req0_valid = vecs[i].r0v; req0_addr = vecs[i].r0a; req0_wdata = vecs[i].r0d;
      req1_valid = vecs[i].r1v; req1_addr = vecs[i].r1a; req1_wdata = vecs[i].r1d;
      rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
      @(negedge clk);
      chk($sformatf("v%0d rd_write", i), 64'(rd_write), 64'(vecs[i].w));
      chk($sformatf("v%0d rd_addr", i), 64'(rd_addr), 64'(vecs[i].a));
      chk($sformatf("v%0d rd_wdata", i), 64'(rd_wdata), 64'(vecs[i].d));
      chk($sformatf("v%0d ready0", i), 64'(req0_ready), 64'(vecs[i].y0));
      chk($sformatf("v%0d ready1", i), 64'(req1_ready), 64'(vecs[i].y1));
      chk($sformatf("v%0d pend1", i), 64'(rs1_pending), 64'(vecs[i].p1));
      chk($sformatf("v%0d pend2", i), 64'(rs2_pending), 64'(vecs[i].p2));
      next_cycle();
    end
    idle_inputs();

    // Reset mid-drain: both holds full, then asynchronous reset
    req0_valid = 1'b1; req0_addr = 5'd10; req0_wdata = 32'hAAAA;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_wdata = 32'hBBBB;
    rs1_addr = 5'd10; rs2_addr = 5'd11;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("drain rd_write", 64'(rd_write), 64'd1);
    chk("drain pend1", 64'(rs1_pending), 64'd1);
    chk("drain pend2", 64'(rs2_pending), 64'd1);
    #1 rst = 1'b1;
    #1 chk_all_zero("drain rst");
    next_cycle();
    rst = 1'b0;

`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
    // Reset mid-clear at cnt=10, clear must restart from x1
    clear_seq(9);
    @(negedge clk);
    chk("midclr rd_addr", 64'(rd_addr), 64'd10);
    #1 rst = 1'b1;
    #1 chk_all_zero("midclr rst");
    next_cycle();
    rst = 1'b0;
`endif
    post_reset_run();

    // Dropped holds must never reach the regfile
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stale rd_write", 64'(rd_write), 64'd0);
      chk("stale pend1", 64'(rs1_pending), 64'd0);
      chk("stale pend2", 64'(rs2_pending), 64'd0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
